// File: rtl/ahb_lite_arb_2m.sv
// Two-master to one-master AHB-Lite arbiter. Port S0 is the CPU, port S1 the DMAC;
// a master that loses arbitration is stalled on its HREADY while its address phase waits in a hold buffer.
module ahb_lite_arb_2m #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic [31:0] S0_HADDR,
    input  logic [1:0]  S0_HTRANS,
    input  logic [2:0]  S0_HSIZE,
    input  logic        S0_HWRITE,
    input  logic [31:0] S0_HWDATA,
    output logic        S0_HREADY,
    output logic [31:0] S0_HRDATA,
    output logic        S0_HRESP,

    input  logic [31:0] S1_HADDR,
    input  logic [1:0]  S1_HTRANS,
    input  logic [2:0]  S1_HSIZE,
    input  logic        S1_HWRITE,
    input  logic [31:0] S1_HWDATA,
    output logic        S1_HREADY,
    output logic [31:0] S1_HRDATA,
    output logic        S1_HRESP,

    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic [2:0]  M_HSIZE,
    output logic        M_HWRITE,
    output logic [31:0] M_HWDATA,
    input  logic        M_HREADY,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Per-port hold buffers
    logic        pend0;
    logic [31:0] hold0_addr;
    logic [2:0]  hold0_size;
    logic        hold0_write;

    logic        pend1;
    logic [31:0] hold1_addr;
    logic [2:0]  hold1_size;
    logic        hold1_write;

    // Data-phase ownership and arbitration history (0 = S0, 1 = S1)
    logic        d_vld;
    logic        d_own;
    logic        last_grant;

    // Last issued address phase, replayed on the bus when nothing is issued
    logic [31:0] last_addr;
    logic [2:0]  last_size;
    logic        last_write;

    // Effective requests
    logic        eff0_vld;
    logic [31:0] eff0_addr;
    logic [2:0]  eff0_size;
    logic        eff0_write;

    logic        eff1_vld;
    logic [31:0] eff1_addr;
    logic [2:0]  eff1_size;
    logic        eff1_write;

    logic        tie_to_s1;
    logic        grant0;
    logic        grant1;
    logic        win_vld;
    logic [31:0] win_addr;
    logic [2:0]  win_size;
    logic        win_write;

    logic        issue0;
    logic        issue1;
    logic        cap0;
    logic        cap1;

    logic        unused_htrans_lsb;
    assign unused_htrans_lsb = ^{S0_HTRANS[0], S1_HTRANS[0]};

    always_comb begin
        eff0_vld   = pend0 | S0_HTRANS[1];
        eff0_addr  = pend0 ? hold0_addr  : S0_HADDR;
        eff0_size  = pend0 ? hold0_size  : S0_HSIZE;
        eff0_write = pend0 ? hold0_write : S0_HWRITE;

        eff1_vld   = pend1 | S1_HTRANS[1];
        eff1_addr  = pend1 ? hold1_addr  : S1_HADDR;
        eff1_size  = pend1 ? hold1_size  : S1_HSIZE;
        eff1_write = pend1 ? hold1_write : S1_HWRITE;
    end

    // On a tie, round-robin hands the grant to the port not granted last; fixed priority favours the DMA.
    always_comb begin
        tie_to_s1 = (ROUND_ROBIN != 0) ? (last_grant == 1'b0) : 1'b1;
        grant1    = eff1_vld & (~eff0_vld | tie_to_s1);
        grant0    = eff0_vld & ~grant1;
        win_vld   = grant0 | grant1;

        win_addr  = last_addr;
        win_size  = last_size;
        win_write = last_write;
        if (grant1) begin
            win_addr  = eff1_addr;
            win_size  = eff1_size;
            win_write = eff1_write;
        end else if (grant0) begin
            win_addr  = eff0_addr;
            win_size  = eff0_size;
            win_write = eff0_write;
        end
    end

    always_comb begin
        issue0 = M_HREADY & grant0;
        issue1 = M_HREADY & grant1;
        cap0   = S0_HREADY & S0_HTRANS[1] & ~pend0 & ~issue0;
        cap1   = S1_HREADY & S1_HTRANS[1] & ~pend1 & ~issue1;
    end

    // Fabric address phase
    always_comb begin
        M_HADDR  = win_addr;
        M_HSIZE  = win_size;
        M_HWRITE = win_write;
        M_HTRANS = win_vld ? TRANS_NONSEQ : TRANS_IDLE;
    end

    // Data phase routing: the owner's HREADY follows the fabric so a two-cycle ERROR passes through intact.
    always_comb begin
        S0_HREADY = 1'b1;
        if (d_vld && d_own == 1'b0) begin
            S0_HREADY = M_HREADY;
        end else if (pend0) begin
            S0_HREADY = 1'b0;
        end

        S1_HREADY = 1'b1;
        if (d_vld && d_own == 1'b1) begin
            S1_HREADY = M_HREADY;
        end else if (pend1) begin
            S1_HREADY = 1'b0;
        end

        S0_HRESP  = (d_vld && d_own == 1'b0) ? M_HRESP : 1'b0;
        S1_HRESP  = (d_vld && d_own == 1'b1) ? M_HRESP : 1'b0;
        S0_HRDATA = M_HRDATA;
        S1_HRDATA = M_HRDATA;

        M_HWDATA = 32'h0;
        if (d_vld) begin
            M_HWDATA = d_own ? S1_HWDATA : S0_HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_vld      <= 1'b0;
            d_own      <= 1'b0;
            last_grant <= 1'b1;
            last_addr  <= 32'h0;
            last_size  <= 3'b000;
            last_write <= 1'b0;
        end else if (M_HREADY) begin
            if (win_vld) begin
                d_vld      <= 1'b1;
                d_own      <= grant1;
                last_grant <= grant1;
                last_addr  <= win_addr;
                last_size  <= win_size;
                last_write <= win_write;
            end else begin
                d_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend0       <= 1'b0;
            hold0_addr  <= 32'h0;
            hold0_size  <= 3'b000;
            hold0_write <= 1'b0;
        end else if (issue0) begin
            pend0 <= 1'b0;
        end else if (cap0) begin
            pend0       <= 1'b1;
            hold0_addr  <= S0_HADDR;
            hold0_size  <= S0_HSIZE;
            hold0_write <= S0_HWRITE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend1       <= 1'b0;
            hold1_addr  <= 32'h0;
            hold1_size  <= 3'b000;
            hold1_write <= 1'b0;
        end else if (issue1) begin
            pend1 <= 1'b0;
        end else if (cap1) begin
            pend1       <= 1'b1;
            hold1_addr  <= S1_HADDR;
            hold1_size  <= S1_HSIZE;
            hold1_write <= S1_HWRITE;
        end
    end

    // A port is never both waiting in its hold buffer and owning the data phase.
    a_pend0_excl: assert property (@(posedge HCLK) disable iff (HRESET)
        !(pend0 && d_vld && d_own == 1'b0));
    a_pend1_excl: assert property (@(posedge HCLK) disable iff (HRESET)
        !(pend1 && d_vld && d_own == 1'b1));

endmodule

// File: tb/tb_ahb_lite_arb_2m.sv
// Directed bench for ahb_lite_arb_2m: a round-robin and a fixed-priority instance share
// the same stimulus; outputs are sampled at the falling edge and compared to hand-derived values.
module tb_ahb_lite_arb_2m;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] S0_HADDR, S1_HADDR, S0_HWDATA, S1_HWDATA, M_HRDATA;
  logic [1:0]  S0_HTRANS, S1_HTRANS;
  logic [2:0]  S0_HSIZE, S1_HSIZE;
  logic        S0_HWRITE, S1_HWRITE, M_HREADY, M_HRESP;

  logic        rr_s0_hready, rr_s1_hready, rr_s0_hresp, rr_s1_hresp;
  logic [31:0] rr_s0_hrdata, rr_s1_hrdata, rr_m_haddr, rr_m_hwdata;
  logic [1:0]  rr_m_htrans;
  logic [2:0]  rr_m_hsize;
  logic        rr_m_hwrite;

  logic        fp_s0_hready, fp_s1_hready, fp_s0_hresp, fp_s1_hresp;
  logic [31:0] fp_s0_hrdata, fp_s1_hrdata, fp_m_haddr, fp_m_hwdata;
  logic [1:0]  fp_m_htrans;
  logic [2:0]  fp_m_hsize;
  logic        fp_m_hwrite;

  int n_checks = 0;
  int n_errors = 0;

  ahb_lite_arb_2m #(.ROUND_ROBIN(1)) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS), .S0_HSIZE(S0_HSIZE), .S0_HWRITE(S0_HWRITE),
    .S0_HWDATA(S0_HWDATA), .S0_HREADY(rr_s0_hready), .S0_HRDATA(rr_s0_hrdata), .S0_HRESP(rr_s0_hresp),
    .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS), .S1_HSIZE(S1_HSIZE), .S1_HWRITE(S1_HWRITE),
    .S1_HWDATA(S1_HWDATA), .S1_HREADY(rr_s1_hready), .S1_HRDATA(rr_s1_hrdata), .S1_HRESP(rr_s1_hresp),
    .M_HADDR(rr_m_haddr), .M_HTRANS(rr_m_htrans), .M_HSIZE(rr_m_hsize), .M_HWRITE(rr_m_hwrite),
    .M_HWDATA(rr_m_hwdata), .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
  );

  ahb_lite_arb_2m #(.ROUND_ROBIN(0)) dut_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS), .S0_HSIZE(S0_HSIZE), .S0_HWRITE(S0_HWRITE),
    .S0_HWDATA(S0_HWDATA), .S0_HREADY(fp_s0_hready), .S0_HRDATA(fp_s0_hrdata), .S0_HRESP(fp_s0_hresp),
    .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS), .S1_HSIZE(S1_HSIZE), .S1_HWRITE(S1_HWRITE),
    .S1_HWDATA(S1_HWDATA), .S1_HREADY(fp_s1_hready), .S1_HRDATA(fp_s1_hrdata), .S1_HRESP(fp_s1_hresp),
    .M_HADDR(fp_m_haddr), .M_HTRANS(fp_m_htrans), .M_HSIZE(fp_m_hsize), .M_HWRITE(fp_m_hwrite),
    .M_HWDATA(fp_m_hwdata), .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
  );

  // Clock / reset
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic drive_idle();
    S0_HADDR = 32'h0; S0_HTRANS = 2'b00; S0_HSIZE = 3'b010; S0_HWRITE = 1'b0; S0_HWDATA = 32'h0;
    S1_HADDR = 32'h0; S1_HTRANS = 2'b00; S1_HSIZE = 3'b010; S1_HWRITE = 1'b0; S1_HWDATA = 32'h0;
    M_HREADY = 1'b1; M_HRESP = 1'b0; M_HRDATA = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic s0_req(input logic [31:0] addr, input logic [2:0] size, input logic wr);
    S0_HADDR = addr; S0_HSIZE = size; S0_HWRITE = wr; S0_HTRANS = 2'b10;
  endtask

  task automatic s1_req(input logic [31:0] addr, input logic [2:0] size, input logic wr);
    S1_HADDR = addr; S1_HSIZE = size; S1_HWRITE = wr; S1_HTRANS = 2'b10;
  endtask

  initial begin
    drive_idle();
    HRESET = 1'b0;

    // Reset state
    do_reset();
    settle();
    check_eq("rst_htrans", 32'(rr_m_htrans), 32'h0);
    check_eq("rst_s0_hready", 32'(rr_s0_hready), 32'h1);
    check_eq("rst_s1_hready", 32'(rr_s1_hready), 32'h1);
    check_eq("rst_s0_hresp", 32'(rr_s0_hresp), 32'h0);
    check_eq("rst_s1_hresp", 32'(rr_s1_hresp), 32'h0);
    check_eq("rst_hwdata", rr_m_hwdata, 32'h0);

    // Uncontested CPU read issues in the same cycle
    tick();
    s0_req(32'h0000_1000, 3'b010, 1'b0);
    settle();
    check_eq("t1_haddr", rr_m_haddr, 32'h0000_1000);
    check_eq("t1_htrans", 32'(rr_m_htrans), 32'h2);
    check_eq("t1_hwrite", 32'(rr_m_hwrite), 32'h0);
    check_eq("t1_s1_hready_a", 32'(rr_s1_hready), 32'h1);
    tick();
    S0_HTRANS = 2'b00;
    M_HRDATA = 32'h1111_2222;
    settle();
    check_eq("t1_s0_hrdata", rr_s0_hrdata, 32'h1111_2222);
    check_eq("t1_s0_hready", 32'(rr_s0_hready), 32'h1);
    check_eq("t1_s1_hready_d", 32'(rr_s1_hready), 32'h1);
    check_eq("t1_htrans_idle", 32'(rr_m_htrans), 32'h0);

    // Contention with round-robin: S0 first, S1 replayed from its hold buffer
    do_reset();
    s0_req(32'h0000_2000, 3'b010, 1'b0);
    s1_req(32'h0000_3000, 3'b001, 1'b0);
    settle();
    check_eq("t2_haddr_a", rr_m_haddr, 32'h0000_2000);
    check_eq("t2_s1_hready_a", 32'(rr_s1_hready), 32'h1);
    tick();
    drive_idle();
    S1_HADDR = 32'h0000_BAD0;
    S0_HADDR = 32'h0000_BAD4;
    settle();
    check_eq("t2_haddr_b", rr_m_haddr, 32'h0000_3000);
    check_eq("t2_hsize_b", 32'(rr_m_hsize), 32'h1);
    check_eq("t2_hwrite_b", 32'(rr_m_hwrite), 32'h0);
    check_eq("t2_htrans_b", 32'(rr_m_htrans), 32'h2);
    check_eq("t2_s1_hready_b", 32'(rr_s1_hready), 32'h0);
    check_eq("t2_s0_hready_b", 32'(rr_s0_hready), 32'h1);
    tick();
    settle();
    check_eq("t2_htrans_c", 32'(rr_m_htrans), 32'h0);
    check_eq("t2_s1_hready_c", 32'(rr_s1_hready), 32'h1);
    check_eq("t2_haddr_hold", rr_m_haddr, 32'h0000_3000);
    tick();

    // Same contention with fixed priority: S1 first, S0 held
    do_reset();
    s0_req(32'h0000_2000, 3'b010, 1'b0);
    s1_req(32'h0000_3000, 3'b001, 1'b0);
    settle();
    check_eq("t3_haddr_a", fp_m_haddr, 32'h0000_3000);
    check_eq("t3_hsize_a", 32'(fp_m_hsize), 32'h1);
    check_eq("t3_s0_hready_a", 32'(fp_s0_hready), 32'h1);
    tick();
    drive_idle();
    S0_HADDR = 32'h0000_BAD0;
    settle();
    check_eq("t3_haddr_b", fp_m_haddr, 32'h0000_2000);
    check_eq("t3_hsize_b", 32'(fp_m_hsize), 32'h2);
    check_eq("t3_htrans_b", 32'(fp_m_htrans), 32'h2);
    check_eq("t3_s0_hready_b", 32'(fp_s0_hready), 32'h0);
    check_eq("t3_s1_hready_b", 32'(fp_s1_hready), 32'h1);
    tick();
    settle();
    check_eq("t3_s0_hready_c", 32'(fp_s0_hready), 32'h1);
    check_eq("t3_htrans_c", 32'(fp_m_htrans), 32'h0);
    tick();

    // DMA write with 3 wait states; CPU request captured during the waits
    do_reset();
    s1_req(32'h0000_4000, 3'b010, 1'b1);
    settle();
    check_eq("t4_haddr_a", rr_m_haddr, 32'h0000_4000);
    check_eq("t4_hwrite_a", 32'(rr_m_hwrite), 32'h1);
    check_eq("t4_htrans_a", 32'(rr_m_htrans), 32'h2);
    tick();
    S1_HTRANS = 2'b00;
    S1_HWDATA = 32'hCAFE_F00D;
    M_HREADY = 1'b0;
    settle();
    check_eq("t4_hwdata_b", rr_m_hwdata, 32'hCAFE_F00D);
    check_eq("t4_s1_hready_b", 32'(rr_s1_hready), 32'h0);
    check_eq("t4_htrans_b", 32'(rr_m_htrans), 32'h0);
    tick();
    s0_req(32'h0000_5000, 3'b010, 1'b0);
    settle();
    check_eq("t4_hwdata_c", rr_m_hwdata, 32'hCAFE_F00D);
    check_eq("t4_s1_hready_c", 32'(rr_s1_hready), 32'h0);
    check_eq("t4_s0_hready_c", 32'(rr_s0_hready), 32'h1);
    check_eq("t4_haddr_c", rr_m_haddr, 32'h0000_5000);
    tick();
    S0_HTRANS = 2'b00;
    S0_HADDR = 32'h0000_BAD0;
    settle();
    check_eq("t4_hwdata_d", rr_m_hwdata, 32'hCAFE_F00D);
    check_eq("t4_s1_hready_d", 32'(rr_s1_hready), 32'h0);
    check_eq("t4_s0_hready_d", 32'(rr_s0_hready), 32'h0);
    check_eq("t4_haddr_d", rr_m_haddr, 32'h0000_5000);
    tick();
    M_HREADY = 1'b1;
    settle();
    check_eq("t4_hwdata_e", rr_m_hwdata, 32'hCAFE_F00D);
    check_eq("t4_s1_hready_e", 32'(rr_s1_hready), 32'h1);
    check_eq("t4_s0_hready_e", 32'(rr_s0_hready), 32'h0);
    check_eq("t4_htrans_e", 32'(rr_m_htrans), 32'h2);
    check_eq("t4_haddr_e", rr_m_haddr, 32'h0000_5000);
    tick();
    S1_HWDATA = 32'h0;
    M_HRDATA = 32'h55AA_55AA;
    settle();
    check_eq("t4_s0_hready_f", 32'(rr_s0_hready), 32'h1);
    check_eq("t4_s0_hrdata_f", rr_s0_hrdata, 32'h55AA_55AA);
    check_eq("t4_hwdata_f", rr_m_hwdata, 32'h0);
    check_eq("t4_htrans_f", 32'(rr_m_htrans), 32'h0);
    tick();

    // Two-cycle ERROR response on the DMA data phase
    s1_req(32'h0000_6000, 3'b010, 1'b0);
    settle();
    check_eq("t5_htrans_a", 32'(rr_m_htrans), 32'h2);
    tick();
    S1_HTRANS = 2'b00;
    M_HRESP = 1'b1;
    M_HREADY = 1'b0;
    settle();
    check_eq("t5_s1_hresp_1", 32'(rr_s1_hresp), 32'h1);
    check_eq("t5_s1_hready_1", 32'(rr_s1_hready), 32'h0);
    check_eq("t5_s0_hresp_1", 32'(rr_s0_hresp), 32'h0);
    tick();
    M_HREADY = 1'b1;
    settle();
    check_eq("t5_s1_hresp_2", 32'(rr_s1_hresp), 32'h1);
    check_eq("t5_s1_hready_2", 32'(rr_s1_hready), 32'h1);
    check_eq("t5_s0_hresp_2", 32'(rr_s0_hresp), 32'h0);
    tick();
    M_HRESP = 1'b0;
    settle();
    check_eq("t5_s1_hresp_3", 32'(rr_s1_hresp), 32'h0);
    tick();

    // Reset while a CPU request is held and the DMA owns the data phase
    s1_req(32'h0000_7000, 3'b010, 1'b0);
    tick();
    S1_HTRANS = 2'b00;
    M_HREADY = 1'b0;
    s0_req(32'h0000_8000, 3'b010, 1'b0);
    settle();
    check_eq("t6_s0_hready_a", 32'(rr_s0_hready), 32'h1);
    tick();
    S0_HTRANS = 2'b00;
    settle();
    check_eq("t6_s0_hready_held", 32'(rr_s0_hready), 32'h0);
    check_eq("t6_s1_hready_wait", 32'(rr_s1_hready), 32'h0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    M_HREADY = 1'b1;
    settle();
    check_eq("t6_htrans_rst", 32'(rr_m_htrans), 32'h0);
    check_eq("t6_s0_hready_rst", 32'(rr_s0_hready), 32'h1);
    check_eq("t6_s1_hready_rst", 32'(rr_s1_hready), 32'h1);
    check_eq("t6_s1_hresp_rst", 32'(rr_s1_hresp), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check_eq("t6_no_replay", 32'(rr_m_htrans), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb_2m.md
Name: ahb_lite_arb_2m

Overview:
- Two-master to one-master AHB-Lite arbiter. Sits directly downstream of the single-channel DMA controller's master port, between that port, the CPU master port and the system bus fabric.
- AHB-Lite masters have no request/grant signals. A master that loses arbitration is stalled through its HREADY, and its address phase is held in a per-port buffer until it is issued downstream.
- Port S0 is the CPU. Port S1 is the DMAC.

Parameters:
ROUND_ROBIN  1  1: on a tie, grant the port not granted last; 0: fixed priority, S1 (DMA) wins ties

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous, active-high reset
S0_HADDR  in  32  CPU address
S0_HTRANS  in  2  CPU transfer type
S0_HSIZE  in  3  CPU size
S0_HWRITE  in  1  CPU write
S0_HWDATA  in  32  CPU write data
S0_HREADY  out  1  ready to CPU
S0_HRDATA  out  32  read data to CPU
S0_HRESP  out  1  response to CPU
S1_HADDR, S1_HTRANS, S1_HSIZE, S1_HWRITE, S1_HWDATA, S1_HREADY, S1_HRDATA, S1_HRESP  same as S0  DMAC side
M_HADDR  out  32  fabric address
M_HTRANS  out  2  fabric transfer type
M_HSIZE  out  3  fabric size
M_HWRITE  out  1  fabric write
M_HWDATA  out  32  fabric write data
M_HREADY  in  1  fabric ready
M_HRDATA  in  32  fabric read data
M_HRESP  in  1  fabric response

Behaviour:
- Request validity:
  - Sx request is active when Sx_HTRANS[1]=1. BUSY and IDLE both count as no request.
  - Downstream, every issued transfer is driven as NONSEQ (2'b10), because bursts can be split by arbitration. When nothing is issued, M_HTRANS=2'b00.
- Hold buffer per port: hold_x holds {HADDR, HSIZE, HWRITE} plus a flag pend_x.
  - The effective request of port x is hold_x if pend_x=1, otherwise the live Sx inputs when Sx_HTRANS[1]=1.
- Arbitration and address phase:
  - Combinational each cycle over the effective requests. One request alone wins.
  - On a tie: if ROUND_ROBIN=1, the port not in last_grant wins; if ROUND_ROBIN=0, S1 wins.
  - The winner's effective request drives M_HADDR, M_HSIZE and M_HWRITE. With no winner, these hold the values of the last issued transfer.
- Issue and data ownership, at an edge with M_HREADY=1:
  - The winner is issued.
  - d_own ← winner, d_vld ← 1, last_grant ← winner, pend_winner ← 0.
  - With no winner, d_vld ← 0.
- Capture into the hold buffer, at an edge where all of the following hold for port x:
  - Sx_HREADY=1;
  - Sx_HTRANS[1]=1;
  - pend_x=0;
  - x was not issued at that edge.
  - Then hold_x ← live Sx request and pend_x ← 1.
  - If M_HREADY=0, no issue happens at that edge, so a port presenting a request under the conditions above is captured.
- Sx_HREADY (combinational):
  - d_vld and d_own=x: equals M_HREADY.
  - Otherwise pend_x=1: 0.
  - Otherwise: 1.
- Data phase routing:
  - M_HWDATA = HWDATA of d_own when d_vld, else 0.
  - Sx_HRDATA = M_HRDATA for both ports (broadcast).
  - Sx_HRESP = M_HRESP when d_vld and d_own=x, else 0.
  - The two-cycle ERROR response passes through unchanged, because the owner's HREADY follows M_HREADY.
- Latency:
  - An uncontested request is issued in the same cycle (zero added latency).
  - A request that loses arbitration is issued at the earliest next edge with M_HREADY=1 at which it wins.
- Reset (synchronous): pend_0=pend_1=0, d_vld=0, last_grant=S1, so S0 wins the first tie.
  - After reset: M_HTRANS=2'b00, S0_HREADY=S1_HREADY=1, Sx_HRESP=0.
  - Reset asserted mid-transfer discards held requests and data ownership with no further fabric activity.
- Invariants:
  - pend_x and (d_vld & d_own=x) are never both 1.
  - At most one transfer is in the address phase and one in the data phase.

Test Plan:
- Reset, then S0 reads 0x1000 alone, M_HREADY=1 -> M_HADDR=0x1000 and M_HTRANS=2'b10 in the same cycle; the next cycle S0_HRDATA=M_HRDATA and S0_HREADY=1; S1_HREADY stays 1.
- S0 and S1 request NONSEQ in the same cycle (S0 read 0x2000, S1 read 0x3000), ROUND_ROBIN=1, fresh reset -> S0 issued first; pend_1 set; S1_HREADY=0 for exactly one cycle; 0x3000 issued the following cycle from the hold buffer with its size/write unchanged.
- Same contention with ROUND_ROBIN=0 -> S1 (0x3000) issued first, S0 held; S0_HREADY low one cycle.
- DMA write to 0x4000 with WDATA 0xCAFEF00D; the fabric inserts 3 wait states -> M_HWDATA=0xCAFEF00D throughout; S1_HREADY tracks M_HREADY; a CPU request arriving during the wait states is captured and issued on the edge that completes the write.
- Fabric returns ERROR (HRESP=1 for two cycles, HREADY 0 then 1) on S1's data phase -> S1_HRESP=1 for both cycles; S0_HRESP stays 0.
- HRESET asserted while pend_0=1 and d_vld=1 -> the next cycle M_HTRANS=2'b00, both HREADY=1, and the held address is never issued.
